// File: rtl/gh_round_seq_ctrl.sv
// Round sequencer for the compression function g_N(h,m) = E(LPS(h^N), m) ^ h ^ m.
// Key-schedule and state operations are interleaved on one shared, 2-cycle LPS unit.
module gh_round_seq_ctrl #(
    parameter int LAT    = 2,
    parameter int ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         start,
    input  logic [511:0] h_in,
    input  logic [511:0] m_in,
    input  logic [511:0] n_in,
    output logic         busy,
    output logic         done,
    output logic [511:0] h_out,
    output logic [3:0]   c_idx,
    input  logic [511:0] c_val,
    output logic         lps_clken,
    output logic [511:0] lps_arg,
    input  logic [511:0] lps_func,
    output logic [2:0]   dbg_state
);

    // Handshake: a request is taken when start=1, busy=0 and ce=1; done pulses
    // for one ce cycle with h_out valid, and h_out holds until the next done.

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEY0   = 3'd1,
        ST_RKEY   = 3'd2,
        ST_RSTATE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_FINAL  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_KEY   = 2'd1,
        TAG_STATE = 2'd2
    } tag_t;

    state_t       state_q;
    state_t       state_nxt;
    tag_t         tag_q [LAT];
    tag_t         issue_tag;
    tag_t         tag_out;
    logic [3:0]   round_q;
    logic [511:0] key_q;
    logic [511:0] st_q;
    logic [511:0] h_q;
    logic [511:0] m_q;
    logic [511:0] n_q;

    assign tag_out   = tag_q[LAT-1];
    assign busy      = (state_q != ST_IDLE);
    assign lps_clken = ce;
    assign dbg_state = state_q;

    always_comb begin
        state_nxt = state_q;
        issue_tag = TAG_NONE;
        lps_arg   = '0;
        c_idx     = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_nxt = ST_KEY0;
            end
            ST_KEY0: begin
                lps_arg   = h_q ^ n_q;
                issue_tag = TAG_KEY;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // After the last round only the final state result is awaited.
                if (round_q == 4'(ROUNDS + 1)) begin
                    if (tag_out == TAG_STATE) state_nxt = ST_FINAL;
                end else if (tag_out == TAG_KEY) begin
                    state_nxt = ST_RKEY;
                end
            end
            ST_RKEY: begin
                c_idx     = round_q - 4'd1;
                lps_arg   = key_q ^ c_val;
                issue_tag = TAG_KEY;
                state_nxt = ST_RSTATE;
            end
            ST_RSTATE: begin
                // key_q is still K_i: K_{i+1} lands one cycle later.
                lps_arg   = key_q ^ st_q;
                issue_tag = TAG_STATE;
                state_nxt = ST_WAIT;
            end
            ST_FINAL: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < LAT; i++) tag_q[i] <= TAG_NONE;
            round_q <= '0;
            key_q   <= '0;
            st_q    <= '0;
            h_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            h_out   <= '0;
            done    <= 1'b0;
        end else if (ce) begin
            state_q  <= state_nxt;
            tag_q[0] <= issue_tag;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
            done <= 1'b0;

            if (tag_out == TAG_KEY)   key_q <= lps_func;
            if (tag_out == TAG_STATE) st_q  <= lps_func;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        h_q     <= h_in;
                        m_q     <= m_in;
                        n_q     <= n_in;
                        st_q    <= m_in;
                        round_q <= '0;
                    end
                end
                ST_KEY0:   round_q <= 4'd1;
                ST_RSTATE: round_q <= round_q + 4'd1;
                ST_FINAL: begin
                    h_out <= key_q ^ st_q ^ h_q ^ m_q;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gh_round_seq_ctrl.sv
// Bench for gh_round_seq_ctrl: identity LPS with 2-cycle delay, c_val = c_idx+1,
// and a per-block model of the issue schedule and the compression result.
module tb_gh_round_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic         start;
    logic [511:0] h_in;
    logic [511:0] m_in;
    logic [511:0] n_in;
    logic         busy;
    logic         done;
    logic [511:0] h_out;
    logic [3:0]   c_idx;
    logic [511:0] c_val;
    logic         lps_clken;
    logic [511:0] lps_arg;
    logic [511:0] lps_func;
    logic [2:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gh_round_seq_ctrl dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start),
        .h_in(h_in), .m_in(m_in), .n_in(n_in),
        .busy(busy), .done(done), .h_out(h_out),
        .c_idx(c_idx), .c_val(c_val), .lps_clken(lps_clken),
        .lps_arg(lps_arg), .lps_func(lps_func), .dbg_state(dbg_state)
    );

    // Identity LPS unit: two registered stages gated by lps_clken.
    logic [511:0] p1 = '0;
    logic [511:0] p2 = '0;
    always @(posedge clk) begin
        if (lps_clken) begin
            p1 <= lps_arg;
            p2 <= p1;
        end
    end
    assign lps_func = p2;
    assign c_val    = 512'(c_idx) + 512'd1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Block-level model: expected lps_arg / c_idx per active cycle, and the result.
    logic [511:0] exp_arg  [0:42];
    logic [3:0]   exp_cidx [0:42];
    logic [511:0] exp_pend = '0;
    logic [511:0] exp_hout = '0;
    int           mp = 0;

    function automatic logic [511:0] g_model(input logic [511:0] h, m, n);
        logic [511:0] k, s;
        k = h ^ n;
        s = m;
        for (int i = 1; i <= 12; i++) begin
            s = k ^ s;
            k = k ^ 512'(i);
        end
        return k ^ s ^ h ^ m;
    endfunction

    task automatic model_load(input logic [511:0] h, m, n);
        logic [511:0] k, s;
        for (int p = 0; p <= 42; p++) begin
            exp_arg[p]  = '0;
            exp_cidx[p] = '0;
        end
        k = h ^ n;
        s = m;
        exp_arg[1] = h ^ n;
        for (int i = 1; i <= 12; i++) begin
            exp_arg[3*i+1]  = k ^ 512'(i);
            exp_cidx[3*i+1] = 4'(i - 1);
            exp_arg[3*i+2]  = k ^ s;
            s = k ^ s;
            k = k ^ 512'(i);
        end
        exp_pend = g_model(h, m, n);
    endtask

    initial model_load('0, '0, '0);

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy",  512'(busy), 512'd0);
            chk("rst_done",  512'(done), 512'd0);
            chk("rst_hout",  h_out, 512'd0);
            chk("rst_arg",   lps_arg, 512'd0);
            chk("rst_cidx",  512'(c_idx), 512'd0);
            mp       = 0;
            exp_hout = '0;
        end else begin
            chk("busy",  512'(busy), 512'(mp >= 1 && mp <= 41));
            chk("done",  512'(done), 512'(mp == 42));
            chk("hout",  h_out, exp_hout);
            chk("arg",   lps_arg, exp_arg[mp]);
            chk("cidx",  512'(c_idx), 512'(exp_cidx[mp]));
            if (ce) begin
                if ((mp == 0 || mp == 42) && start) begin
                    model_load(h_in, m_in, n_in);
                    mp = 1;
                end else if (mp >= 1 && mp <= 41) begin
                    mp++;
                    if (mp == 42) exp_hout = exp_pend;
                end else begin
                    mp = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic wait_done(input int base, input int exp_lat, input string nm);
        int lat;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - base;
                break;
            end
        end
        chk(nm, 512'(lat), 512'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run_block(input logic [511:0] h, m, n, input string nm);
        int c0;
        h_in  = h;
        m_in  = m;
        n_in  = n;
        start = 1'b1;
        c0    = cyc;
        tick(1);
        start = 1'b0;
        wait_done(c0, 42, nm);
    endtask

    initial begin
        int c0;
        int c1;
        int s1;
        int s2;
        logic [511:0] th, tm, tn;
        rst = 1'b1; ce = 1'b1; start = 1'b0;
        h_in = '0; m_in = '0; n_in = '0;
        tick(3);
        rst = 1'b0;
        tick(2);

        run_block('0, '0, '0, "lat_zero");
        chk("pin_zero", h_out, 512'hE);

        run_block(512'h1, 512'h2, 512'h0, "lat_h1m2");
        chk("pin_h1m2", h_out, 512'hE);

        for (int t = 0; t < 20; t++) begin
            th = rand512(); tm = rand512(); tn = rand512();
            run_block(th, tm, tn, "lat_rand");
            chk("rand_hout", h_out, g_model(th, tm, tn));
        end

        // Two 5-cycle ce stalls, in round 3 and round 9.
        th = rand512(); tm = rand512(); tn = rand512();
        h_in = th; m_in = tm; n_in = tn;
        start = 1'b1;
        c0 = cyc;
        tick(1);
        start = 1'b0;
        s1 = $urandom_range(10, 12);
        tick_to(c0 + s1);
        ce = 1'b0;
        tick(5);
        ce = 1'b1;
        s2 = $urandom_range(28, 30);
        tick_to(c0 + 5 + s2);
        ce = 1'b0;
        tick(5);
        ce = 1'b1;
        wait_done(c0, 52, "lat_stall");
        chk("stall_hout", h_out, g_model(th, tm, tn));

        // start held high: back-to-back blocks accepted in cycles 0 and 42.
        h_in = 512'h1234; m_in = 512'h5678; n_in = 512'h9abc;
        start = 1'b1;
        c0 = cyc;
        wait_done(c0, 42, "b2b_first");
        start = 1'b0;
        wait_done(c0, 84, "b2b_second");
        chk("b2b_hout", h_out, g_model(512'h1234, 512'h5678, 512'h9abc));

        // Asynchronous reset in cycle 20, released in cycle 22, restart in cycle 23.
        th = rand512(); tm = rand512(); tn = rand512();
        h_in = th; m_in = tm; n_in = tn;
        start = 1'b1;
        c0 = cyc;
        tick(1);
        start = 1'b0;
        tick_to(c0 + 20);
        #2 rst = 1'b1;
        tick_to(c0 + 22);
        #2 rst = 1'b0;
        tick_to(c0 + 23);
        h_in = ~th;
        start = 1'b1;
        c1 = cyc;
        tick(1);
        start = 1'b0;
        wait_done(c0, 65, "lat_after_rst");
        chk("rst_new_hout", h_out, g_model(~th, tm, tn));
        chk("rst_base", 512'(c1 - c0), 512'd23);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
